zero_count_sequencer: RTL and testbench

- Multi-cycle zero-count engine for the SPU datapath: counts 0 bits in a wide operand by streaming it, one chunk per cycle, through a single narrow ZeroCounter instance.
- Optional accumulation across operations into a saturating result register.
- Sits between the SPU issue logic (start/abort, operand) and writeback (done, result).
- Trades latency for area versus a full-width combinational count.

---
 rtl/zero_count_sequencer_pkg.sv | 18 +
 rtl/ZeroCounter.sv | 14 +
 rtl/zero_count_sequencer.sv | 89 ++++++++
 tb/tb_zero_count_sequencer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/zero_count_sequencer_pkg.sv
// Shared constants and helpers for the multi-cycle zero-count engine.
`ifndef ZCS_CLOG2
`define ZCS_CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package zero_count_sequencer_pkg;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   function automatic int num_chunks(input int op_w, input int chunk_w);
      return op_w / chunk_w;
   endfunction

   function automatic int idx_width(input int n);
      return `ZCS_CLOG2(n);
   endfunction
endpackage

// File: rtl/ZeroCounter.sv
// Combinational count of 0 bits in a WIDTH-bit word.
module ZeroCounter #(
   parameter int WIDTH = 16,
   localparam int CW   = `ZCS_CLOG2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] din,
   output logic [CW-1:0]    count
);
   always_comb begin
      count = '0;
      for (int i = 0; i < WIDTH; i++)
         count = count + CW'(~din[i]);
   end
endmodule

// File: rtl/zero_count_sequencer.sv
// Streams a wide operand through one narrow ZeroCounter, one chunk per cycle,
// accumulating into a saturating result register.
module zero_count_sequencer
   import zero_count_sequencer_pkg::*;
#(
   parameter int OP_WIDTH    = 64,
   parameter int CHUNK_WIDTH = 16,
   parameter int RES_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 acc,
   input  logic                 abort,
   input  logic [OP_WIDTH-1:0]  operand,
   output logic                 busy,
   output logic                 done,
   output logic [RES_WIDTH-1:0] result,
   output logic                 sat
);
   localparam int NUM_CHUNKS = num_chunks(OP_WIDTH, CHUNK_WIDTH);
   localparam int IDX_W      = idx_width(NUM_CHUNKS);
   localparam int ZC_W       = `ZCS_CLOG2(CHUNK_WIDTH + 1);
   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_CHUNKS - 1);
   localparam logic [RES_WIDTH-1:0] MAXV     = '1;

   logic [1:0]           state;
   logic [OP_WIDTH-1:0]  shreg;
   logic [IDX_W-1:0]     idx;
   logic [RES_WIDTH-1:0] sum;
   logic                 op_sat;
   logic [ZC_W-1:0]      zc;
   logic [RES_WIDTH:0]   raw;
   logic                 clamp;
   logic [RES_WIDTH-1:0] sum_nxt;
   logic                 accept;

   ZeroCounter #(.WIDTH(CHUNK_WIDTH)) u_zc (
      .din   (shreg[CHUNK_WIDTH-1:0]),
      .count (zc)
   );

   // One extra bit on the add exposes the carry that triggers clamping.
   always_comb begin
      raw     = {1'b0, sum} + (RES_WIDTH+1)'(zc);
      clamp   = raw[RES_WIDTH];
      sum_nxt = clamp ? MAXV : raw[RES_WIDTH-1:0];
   end

   assign accept = start && (state == IDLE || state == DONE);
   assign busy   = (state == RUN);
   assign done   = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         shreg  <= '0;
         idx    <= '0;
         sum    <= '0;
         op_sat <= 1'b0;
         result <= '0;
         sat    <= 1'b0;
      end else if (state == RUN) begin
         if (abort) begin
            state <= IDLE;
         end else begin
            sum    <= sum_nxt;
            shreg  <= shreg >> CHUNK_WIDTH;
            idx    <= idx + 1'b1;
            op_sat <= op_sat | clamp;
            if (idx == LAST_IDX) begin
               result <= sum_nxt;
               sat    <= sat | op_sat | clamp;
               state  <= DONE;
            end
         end
      end else if (accept) begin
         // DONE accepts exactly like IDLE so back-to-back issue needs no gap.
         shreg  <= operand;
         idx    <= '0;
         sum    <= acc ? result : '0;
         op_sat <= 1'b0;
         if (!acc) sat <= 1'b0;
         state  <= RUN;
      end else begin
         state <= IDLE;
      end
   end
endmodule

// File: tb/tb_zero_count_sequencer.sv
// Directed bench for zero_count_sequencer with a cycle-level reference model.
module tb_zero_count_sequencer;
   localparam int RW   = 8;
   localparam int MAXV = 255;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0, acc = 1'b0, abort = 1'b0;
   logic [63:0]   operand = '0;
   logic          busy, done, sat;
   logic [RW-1:0] result;

   int total = 0;
   int bad   = 0;

   zero_count_sequencer #(.OP_WIDTH(64), .CHUNK_WIDTH(16), .RES_WIDTH(RW)) dut (
      .clk(clk), .rst(rst), .start(start), .acc(acc), .abort(abort),
      .operand(operand), .busy(busy), .done(done), .result(result), .sat(sat)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int zeros(input logic [63:0] v);
      int n = 0;
      for (int i = 0; i < 64; i++) if (!v[i]) n++;
      return n;
   endfunction

   // Model: an accepted op resolves its answer up front, then waits 4 edges.
   int m_left = 0, m_result = 0, p_res = 0, tot = 0;
   bit m_done = 0, m_sat = 0, p_sat = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left = 0; m_done = 0; m_result = 0; m_sat = 0;
      end else if (m_left > 0) begin
         m_done = 0;
         if (abort) m_left = 0;
         else begin
            m_left--;
            if (m_left == 0) begin m_result = p_res; m_sat = p_sat; m_done = 1; end
         end
      end else begin
         m_done = 0;
         if (start) begin
            tot   = (acc ? m_result : 0) + zeros(operand);
            p_res = (tot > MAXV) ? MAXV : tot;
            p_sat = (acc && m_sat) || (tot > MAXV);
            if (!acc) m_sat = 0;
            m_left = 4;
         end
      end
   end

   always @(negedge clk) begin
      chk("m_busy",   busy,   m_left > 0);
      chk("m_done",   done,   m_done);
      chk("m_result", result, m_result);
      chk("m_sat",    sat,    m_sat);
   end

   // Called on a negedge; returns on the negedge where done is seen.
   task automatic run_op(input logic [63:0] op, input bit a, input bit ab,
                         input int exp_res, input bit exp_sat, input string name);
      int lat;
      start = 1'b1; acc = a; operand = op; abort = ab;
      @(negedge clk);
      start = 1'b0; acc = 1'b0; abort = 1'b0; operand = ~op;
      lat = 0;
      while (!done && lat < 10) begin @(negedge clk); lat++; end
      chk({name, " latency"}, lat, 4);
      chk({name, " result"}, result, exp_res);
      chk({name, " sat"}, sat, exp_sat);
   endtask

   task automatic sat_chain(input string name);
      run_op(64'h0, 1'b0, 1'b0, 64,  1'b0, {name, "1"});
      run_op(64'h0, 1'b1, 1'b0, 128, 1'b0, {name, "2"});
      run_op(64'h0, 1'b1, 1'b0, 192, 1'b0, {name, "3"});
      run_op(64'h0, 1'b1, 1'b0, 255, 1'b1, {name, "4"});
   endtask

   initial begin
      int nd, r;
      repeat (2) @(negedge clk);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset result", result, 0);
      chk("reset sat", sat, 0);
      rst = 1'b0;
      @(negedge clk);

      run_op(64'h0, 1'b0, 1'b0, 64, 1'b0, "zero");
      run_op(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0, 1'b0, "ones");
      run_op(64'h00FF_0000_FFFF_0F0F, 1'b0, 1'b0, 32, 1'b0, "mixed");
      sat_chain("acc");
      run_op(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1, 1'b0, "satclr");

      // start held high, operand changing every cycle
      nd = 0;
      for (int i = 0; i < 15; i++) begin
         start = 1'b1; acc = 1'b0;
         operand = 64'(i + 1) * 64'h0123_4567_89AB_CDEF;
         @(negedge clk);
         if (done) nd++;
         chk("b2b busy", busy, !done);
      end
      start = 1'b0;
      chk("b2b dones", nd, 3);
      repeat (2) @(negedge clk);

      // abort in second RUN cycle
      run_op(64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b0, 7, 1'b0, "seven");
      @(negedge clk);
      start = 1'b1; acc = 1'b0; operand = 64'h0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort busy", busy, 0);
      chk("abort result", result, 7);
      nd = 0;
      repeat (6) begin @(negedge clk); if (done) nd++; end
      chk("abort no done", nd, 0);
      run_op(64'h0, 1'b0, 1'b1, 64, 1'b0, "start+abort");

      // start during RUN is dropped
      @(negedge clk);
      start = 1'b1; acc = 1'b0; operand = 64'hFFFF_FFFF_FFFF_FF80;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; acc = 1'b1; operand = 64'h0;
      @(negedge clk);
      start = 1'b0; acc = 1'b0;
      nd = 0; r = -1;
      repeat (8) begin @(negedge clk); if (done) begin nd++; r = int'(result); end end
      chk("ignored dones", nd, 1);
      chk("ignored result", r, 7);

      // asynchronous reset mid-RUN with sat set
      sat_chain("pre");
      start = 1'b1; acc = 1'b1; operand = 64'h0;
      @(negedge clk);
      start = 1'b0; acc = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst busy", busy, 0);
      chk("arst done", done, 0);
      chk("arst result", result, 0);
      chk("arst sat", sat, 0);
      @(negedge clk);
      rst = 1'b0;
      nd = 0;
      repeat (6) begin @(negedge clk); if (done) nd++; end
      chk("arst no done", nd, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
